// File: rtl/nrdiv_pkg.sv
// Shared definitions for the sequential non-restoring divider:
// FSM state encoding and the counter-width helper.
package nrdiv_pkg;

  // Two-bit state encoding constants
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ITER = ST_ITER,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_e;

  // Ceiling log2, used to size the iteration counter as clog2(WIDTH+1)
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nr_divider_seq_add_sub.sv
// add_sub_n: N-bit ripple-carry adder/subtractor.
// m_i = 0 adds, m_i = 1 subtracts (b inverted, carry-in set).
module add_sub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         m_i,
  output logic [N-1:0] s_o
);

  logic [N-1:0] bx_s;
  logic [N-1:0] c_s;

  assign bx_s   = b_i ^ {N{m_i}};
  assign c_s[0] = m_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s_o[i] = a_i[i] ^ bx_s[i] ^ c_s[i];
    if (i < N - 1) begin : g_carry
      assign c_s[i+1] = (a_i[i] & bx_s[i]) | (c_s[i] & (a_i[i] ^ bx_s[i]));
    end
  end

endmodule

// File: rtl/nr_divider_seq.sv
// nr_divider_seq: sequential non-restoring divider, one quotient bit per
// clock, valid/ready on both operand and result sides, divide-by-zero flag.
// Optional build macro NRDIV_SIGNED_EN selects two's-complement operands
// (magnitude division with truncating sign fix-up in FIX).
module nr_divider_seq
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0
);

  localparam int             CW       = clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     a_q;
  logic [WIDTH-1:0]   qr_q;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH-1:0]   q_q, r_q;
  logic               div0_q;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept_s;
  logic               y_zero_s;
  logic [WIDTH-1:0]   x_mag_s, y_mag_s;
  logic [WIDTH:0]     add_a_s, add_b_s, add_s_s;
  logic               add_m_s;
  logic [WIDTH:0]     a_fix_s;
  logic [WIDTH-1:0]   q_fix_s, r_fix_s;

  assign accept_s = in_valid & in_ready_q;
  assign y_zero_s = (y == ZERO_W);

`ifdef NRDIV_SIGNED_EN
  logic             neg_q_q;
  logic             neg_r_q;
  logic             x_neg_s, y_neg_s;
  logic [WIDTH-1:0] q_neg_s, r_neg_s;

  // Operand magnitudes for two's-complement inputs
  always_comb begin
    x_neg_s = x[WIDTH-1];
    y_neg_s = y[WIDTH-1];
    if (x_neg_s) begin
      x_mag_s = (~x) + ONE_W;
    end else begin
      x_mag_s = x;
    end
    if (y_neg_s) begin
      y_mag_s = (~y) + ONE_W;
    end else begin
      y_mag_s = y;
    end
  end

  // Capture result signs at accept; consumed by the FIX fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q == IDLE && accept_s) begin
      neg_q_q <= x_neg_s ^ y_neg_s;
      neg_r_q <= x_neg_s;
    end else begin
      neg_q_q <= neg_q_q;
      neg_r_q <= neg_r_q;
    end
  end

  // Truncating-division sign fix-up of quotient and remainder
  always_comb begin
    q_neg_s = (~qr_q) + ONE_W;
    r_neg_s = (~a_fix_s[WIDTH-1:0]) + ONE_W;
    if (neg_q_q) begin
      q_fix_s = q_neg_s;
    end else begin
      q_fix_s = qr_q;
    end
    if (neg_r_q) begin
      r_fix_s = r_neg_s;
    end else begin
      r_fix_s = a_fix_s[WIDTH-1:0];
    end
  end
`else
  // Unsigned operands are their own magnitudes
  always_comb begin
    x_mag_s = x;
    y_mag_s = y;
  end

  // Unsigned results need no sign fix-up
  always_comb begin
    q_fix_s = qr_q;
    r_fix_s = a_fix_s[WIDTH-1:0];
  end
`endif

  // Shared adder operand select: shifted-A step in ITER, restore-add in FIX
  always_comb begin
    add_b_s = {1'b0, d_q};
    if (state_q == FIX) begin
      add_a_s = a_q;
      add_m_s = 1'b0;
    end else begin
      add_a_s = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
      add_m_s = ~a_q[WIDTH];
    end
  end

  add_sub_n #(
    .N (WIDTH + 1)
  ) u_add_sub (
    .a_i (add_a_s),
    .b_i (add_b_s),
    .m_i (add_m_s),
    .s_o (add_s_s)
  );

  // Remainder restore: a negative final partial remainder gets D added back
  always_comb begin
    if (a_q[WIDTH]) begin
      a_fix_s = add_s_s;
    end else begin
      a_fix_s = a_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (y_zero_s) begin
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: ready only in IDLE; valid one cycle after DONE entry until handshake
  always_comb begin
    in_ready_d = (state_d == IDLE);
    if (state_q == DONE && !(out_valid_q && out_ready)) begin
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath: operand load, per-step shift/add-sub, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= {(WIDTH+1){1'b0}};
      qr_q   <= ZERO_W;
      d_q    <= ZERO_W;
      cnt_q  <= {CW{1'b0}};
      q_q    <= ZERO_W;
      r_q    <= ZERO_W;
      div0_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            a_q   <= {(WIDTH+1){1'b0}};
            qr_q  <= x_mag_s;
            d_q   <= y_mag_s;
            cnt_q <= {CW{1'b0}};
            if (y_zero_s) begin
              q_q    <= {WIDTH{1'b1}};
              r_q    <= x;
              div0_q <= 1'b1;
            end
          end
        end
        ITER: begin
          a_q   <= add_s_s;
          qr_q  <= {qr_q[WIDTH-2:0], ~add_s_s[WIDTH]};
          cnt_q <= cnt_q + CNT_ONE;
        end
        FIX: begin
          a_q    <= a_fix_s;
          q_q    <= q_fix_s;
          r_q    <= r_fix_s;
          div0_q <= 1'b0;
        end
        DONE: begin
          a_q <= a_q;
        end
        default: begin
          a_q <= a_q;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign div0      = div0_q;

endmodule
